// File: rtl/smi_ram_responder_pkg.sv
// Shared definitions for the SMI block-RAM responder.
// Frame type IDs, status codes, header layout and FSM states.
package smi_ram_responder_pkg;

    localparam logic [7:0] WRITE_REQ    = 8'h01;
    localparam logic [7:0] READ_REQ     = 8'h02;
    localparam logic [7:0] ID_MASK      = 8'hFF;
    localparam logic [7:0] STATUS_OK    = 8'h00;
    localparam logic [7:0] STATUS_RANGE = 8'h01;
    localparam logic [7:0] TERM_EOFC    = 8'd3;

    localparam int TYPE_BYTE   = 0;
    localparam int TAG_BYTE    = 1;
    localparam int STATUS_BYTE = 2;
    localparam int ADDR_BYTE   = 4;
    localparam int LEN_BYTE    = 12;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_HDR,
        RD_DATA,
        DROP
    } stateT;

    // Low three bytes of a response header; remaining bytes are zero.
    function automatic logic [23:0] respHdr(
        input logic [7:0] typ,
        input logic [7:0] tag,
        input logic [7:0] status
    );
        logic [23:0] h;
        h = '0;
        h[TYPE_BYTE*8   +: 8] = typ;
        h[TAG_BYTE*8    +: 8] = tag;
        h[STATUS_BYTE*8 +: 8] = status;
        return h;
    endfunction

endpackage

// File: rtl/smi_ram_responder_byte_en.sv
// Simple dual-port RAM with per-byte write enables.
// Read data is registered: one cycle latency from rdEn.
module smi_ram_byte_en #(
    parameter int AddrWidth = 10,
    parameter int NumBytes  = 16
) (
    input  logic                    clk,
    input  logic                    wrEn,
    input  logic [AddrWidth-1:0]    wrAddr,
    input  logic [NumBytes-1:0]     wrBe,
    input  logic [NumBytes*8-1:0]   wrData,
    input  logic                    rdEn,
    input  logic [AddrWidth-1:0]    rdAddr,
    output logic [NumBytes*8-1:0]   rdData
);

    logic [NumBytes*8-1:0] mem [1<<AddrWidth];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (wrBe[i]) begin
                    mem[wrAddr][i*8 +: 8] <= wrData[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/smi_ram_responder.sv
// SMI target endpoint terminating read/write request frames on a
// block RAM; one transaction in flight, answered before the next.
module smi_ram_responder
    import smi_ram_responder_pkg::*;
#(
    parameter int DataIndexSize = 4,
    parameter int MemIndexSize  = 10,
    parameter int FlitWidth     = 1 << DataIndexSize
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   smiReqReady,
    input  logic [7:0]             smiReqEofc,
    input  logic [FlitWidth*8-1:0] smiReqData,
    output logic                   smiReqStop,
    output logic                   smiRespReady,
    output logic [7:0]             smiRespEofc,
    output logic [FlitWidth*8-1:0] smiRespData,
    input  logic                   smiRespStop
);

    localparam int          DW    = FlitWidth * 8;
    localparam logic [65:0] Depth = 66'd1 << MemIndexSize;

    stateT state, stateNext;

    logic [7:0]  typeReg, tagReg;
    logic [63:0] wordIdx;
    logic        errFlag;
    logic [16:0] nFlits, issueCnt;
    logic [7:0]  lastEofc;

    logic          rdPending, pendLast;
    logic [DW-1:0] fifoData [2];
    logic          fifoLast [2];
    logic [1:0]    fifoCnt;
    logic          wrPtr, rdPtr;

    logic          reqFire, respFire;
    logic [7:0]    reqType, reqTag;
    logic [63:0]   reqAddr, reqIdx;
    logic [15:0]   reqLen;
    logic [16:0]   reqFlits;
    logic          reqRange;
    logic          wrInRange, wrEn;
    logic [FlitWidth-1:0] wrBe;
    logic [DW-1:0] ramRdData, srcData;
    logic          srcLast, srcValid;
    logic          inRd, outFree, outTake, issue;
    logic          push, pop;
    logic [1:0]    occ;
    logic          unusedBits;

    assign reqFire  = smiReqReady & ~smiReqStop;
    assign respFire = smiRespReady & ~smiRespStop;

    assign reqType  = smiReqData[TYPE_BYTE*8 +: 8] & ID_MASK;
    assign reqTag   = smiReqData[TAG_BYTE*8 +: 8];
    assign reqAddr  = smiReqData[ADDR_BYTE*8 +: 64];
    assign reqLen   = smiReqData[LEN_BYTE*8 +: 16];
    assign reqIdx   = reqAddr >> DataIndexSize;
    assign reqFlits = (17'(reqLen) + 17'(FlitWidth - 1)) >> DataIndexSize;
    assign reqRange = ({2'b0, reqIdx} + 66'(reqFlits)) > Depth;

    assign unusedBits = ^{smiReqData[DW-1:LEN_BYTE*8+16],
                          smiReqData[ADDR_BYTE*8-1:16]};

    assign wrInRange = {2'b0, wordIdx} < Depth;
    assign wrEn      = (state == WR_DATA) & reqFire & wrInRange;

    always_comb begin
        wrBe = '0;
        for (int i = 0; i < FlitWidth; i++) begin
            wrBe[i] = (smiReqEofc == 8'd0) || (8'(i) < smiReqEofc);
        end
    end

    // Prefetch: RAM output plus 2-entry FIFO keep the response fed
    // every cycle; the RAM output bypasses an empty FIFO.
    assign inRd     = (state == RD_HDR) | (state == RD_DATA);
    assign outFree  = ~smiRespReady | respFire;
    assign srcValid = (fifoCnt != 2'd0) | rdPending;
    assign outTake  = (state == RD_DATA) & srcValid & outFree;
    assign occ      = fifoCnt + {1'b0, rdPending};
    assign issue    = inRd & ~errFlag & (issueCnt < nFlits)
                    & ((occ - {1'b0, outTake}) < 2'd2);
    assign push     = rdPending & ~(outTake & (fifoCnt == 2'd0));
    assign pop      = outTake & (fifoCnt != 2'd0);
    assign srcData  = (fifoCnt != 2'd0) ? fifoData[rdPtr] : ramRdData;
    assign srcLast  = (fifoCnt != 2'd0) ? fifoLast[rdPtr] : pendLast;

    smi_ram_byte_en #(
        .AddrWidth (MemIndexSize),
        .NumBytes  (FlitWidth)
    ) uRam (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wordIdx[MemIndexSize-1:0]),
        .wrBe   (wrBe),
        .wrData (smiReqData),
        .rdEn   (issue),
        .rdAddr (MemIndexSize'(wordIdx + 64'(issueCnt))),
        .rdData (ramRdData)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        smiReqStop = 1'b0;
        unique case (state)
            IDLE: begin
                if (reqFire) begin
                    if (reqType == WRITE_REQ) begin
                        stateNext = (smiReqEofc == 8'd0) ? WR_DATA : WR_RESP;
                    end else if (reqType == READ_REQ) begin
                        stateNext = RD_HDR;
                    end else if (smiReqEofc == 8'd0) begin
                        stateNext = DROP;
                    end
                end
            end
            WR_DATA: begin
                if (reqFire && smiReqEofc != 8'd0) stateNext = WR_RESP;
            end
            WR_RESP: begin
                smiReqStop = 1'b1;
                if (respFire) stateNext = IDLE;
            end
            RD_HDR: begin
                smiReqStop = 1'b1;
                if (respFire) begin
                    stateNext = (nFlits == 17'd0 || errFlag) ? IDLE : RD_DATA;
                end
            end
            RD_DATA: begin
                smiReqStop = 1'b1;
                if (respFire && smiRespEofc != 8'd0) stateNext = IDLE;
            end
            DROP: begin
                if (reqFire && smiReqEofc != 8'd0) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            smiRespReady <= 1'b0;
            smiRespEofc  <= 8'd0;
            smiRespData  <= '0;
            typeReg      <= 8'd0;
            tagReg       <= 8'd0;
            wordIdx      <= 64'd0;
            errFlag      <= 1'b0;
            nFlits       <= 17'd0;
            lastEofc     <= 8'd0;
            issueCnt     <= 17'd0;
            rdPending    <= 1'b0;
            pendLast     <= 1'b0;
            fifoCnt      <= 2'd0;
            wrPtr        <= 1'b0;
            rdPtr        <= 1'b0;
        end else begin
            rdPending <= issue;
            pendLast  <= (issueCnt == nFlits - 17'd1);
            if (issue) issueCnt <= issueCnt + 17'd1;
            if (push) begin
                fifoData[wrPtr] <= ramRdData;
                fifoLast[wrPtr] <= pendLast;
                wrPtr           <= ~wrPtr;
            end
            if (pop) rdPtr <= ~rdPtr;
            fifoCnt <= fifoCnt + {1'b0, push} - {1'b0, pop};

            unique case (state)
                IDLE: begin
                    if (reqFire) begin
                        typeReg  <= reqType;
                        tagReg   <= reqTag;
                        wordIdx  <= reqIdx;
                        errFlag  <= 1'b0;
                        issueCnt <= 17'd0;
                        if (reqType == READ_REQ) begin
                            nFlits       <= reqFlits;
                            lastEofc     <= 8'(reqLen - 16'((reqFlits - 17'd1)
                                            << DataIndexSize));
                            errFlag      <= reqRange;
                            smiRespReady <= 1'b1;
                            smiRespData  <= DW'(respHdr(reqType, reqTag,
                                            reqRange ? STATUS_RANGE : STATUS_OK));
                            smiRespEofc  <= (reqFlits == 17'd0 || reqRange)
                                            ? TERM_EOFC : 8'd0;
                        end else if (reqType == WRITE_REQ
                                     && smiReqEofc != 8'd0) begin
                            smiRespReady <= 1'b1;
                            smiRespData  <= DW'(respHdr(reqType, reqTag,
                                                        STATUS_OK));
                            smiRespEofc  <= TERM_EOFC;
                        end
                    end
                end
                WR_DATA: begin
                    if (reqFire) begin
                        wordIdx <= wordIdx + 64'd1;
                        if (!wrInRange) errFlag <= 1'b1;
                        if (smiReqEofc != 8'd0) begin
                            smiRespReady <= 1'b1;
                            smiRespData  <= DW'(respHdr(typeReg, tagReg,
                                (errFlag | ~wrInRange) ? STATUS_RANGE
                                                       : STATUS_OK));
                            smiRespEofc  <= TERM_EOFC;
                        end
                    end
                end
                WR_RESP: begin
                    if (respFire) begin
                        smiRespReady <= 1'b0;
                        errFlag      <= 1'b0;
                    end
                end
                RD_HDR: begin
                    if (respFire) begin
                        smiRespReady <= 1'b0;
                        if (nFlits == 17'd0 || errFlag) errFlag <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (outTake) begin
                        smiRespReady <= 1'b1;
                        smiRespData  <= srcData;
                        smiRespEofc  <= srcLast ? lastEofc : 8'd0;
                    end else if (respFire) begin
                        smiRespReady <= 1'b0;
                    end
                end
                DROP: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smi_ram_responder.sv
// Directed self-checking bench for smi_ram_responder.
// Flits driven and sampled on the falling clock edge.
module tb_smi_ram_responder;

    logic         clk = 1'b0;
    logic         srst;
    logic         smiReqReady;
    logic [7:0]   smiReqEofc;
    logic [127:0] smiReqData;
    logic         smiReqStop;
    logic         smiRespReady;
    logic [7:0]   smiRespEofc;
    logic [127:0] smiRespData;
    logic         smiRespStop;

    int  tests = 0;
    int  failed = 0;
    bit  toggleStop = 0;

    localparam logic [127:0] D0 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D1 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] D2 = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
    localparam logic [127:0] P  = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [127:0] Q0 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] Q1 = 128'h55555555_66666666_77777777_88888888;

    logic [127:0] w6;

    smi_ram_responder dut (
        .clk          (clk),
        .srst         (srst),
        .smiReqReady  (smiReqReady),
        .smiReqEofc   (smiReqEofc),
        .smiReqData   (smiReqData),
        .smiReqStop   (smiReqStop),
        .smiRespReady (smiRespReady),
        .smiRespEofc  (smiRespEofc),
        .smiRespData  (smiRespData),
        .smiRespStop  (smiRespStop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] hdr(input logic [7:0] t,
        input logic [7:0] tg, input logic [63:0] a, input logic [15:0] l);
        logic [127:0] h;
        h = '0;
        h[7:0]    = t;
        h[15:8]   = tg;
        h[95:32]  = a;
        h[111:96] = l;
        return h;
    endfunction

    function automatic logic [127:0] rsp(input logic [7:0] t,
        input logic [7:0] tg, input logic [7:0] st);
        logic [127:0] r;
        r = '0;
        r[7:0]   = t;
        r[15:8]  = tg;
        r[23:16] = st;
        return r;
    endfunction

    task automatic sendFlit(input logic [7:0] e, input logic [127:0] d,
                            input bit last);
        int n;
        @(negedge clk);
        smiReqReady = 1'b1;
        smiReqEofc  = e;
        smiReqData  = d;
        n = 0;
        while (smiReqStop && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("reqTimeout", 256'(n), 256'(0));
        @(posedge clk);
        #1;
        if (last) smiReqReady = 1'b0;
    endtask

    task automatic getFlit(output logic [7:0] e, output logic [127:0] d,
                           output int waits);
        bit held;
        bit got;
        logic [7:0] he;
        logic [127:0] hd;
        held = 0;
        got = 0;
        waits = 0;
        e = 8'd0;
        d = '0;
        he = 8'd0;
        hd = '0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            smiRespStop = toggleStop ? ~smiRespStop : 1'b0;
            if (held) begin
                chk("stableHold", {smiRespReady, smiRespEofc, smiRespData},
                    {1'b1, he, hd});
            end
            if (smiRespReady && !smiRespStop) begin
                e = smiRespEofc;
                d = smiRespData;
                got = 1;
            end else begin
                held = smiRespReady;
                he = smiRespEofc;
                hd = smiRespData;
                waits++;
            end
        end
        if (!got) chk("respTimeout", 256'(0), 256'(1));
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (smiRespReady) seen++;
        end
        chk(tag, 256'(seen), 256'(0));
    endtask

    task automatic wrResp(input string tag, input logic [7:0] tg,
                          input logic [7:0] st);
        logic [7:0] e;
        logic [127:0] d;
        int w;
        getFlit(e, d, w);
        chk({tag, "_lat"}, 256'(w), 256'(0));
        chk({tag, "_hdr"}, 256'(d), 256'(rsp(8'h01, tg, st)));
        chk({tag, "_eofc"}, 256'(e), 256'(8'd3));
    endtask

    task automatic doRead(input string tag, input logic [63:0] a,
        input logic [15:0] l, input logic [7:0] tg, input logic [7:0] st,
        input int nd, input logic [127:0] x0, input logic [127:0] x1,
        input logic [127:0] x2, input logic [7:0] lastE);
        logic [7:0] e;
        logic [127:0] d;
        logic [127:0] x;
        int w;
        sendFlit(8'd16, hdr(8'h02, tg, a, l), 1);
        getFlit(e, d, w);
        if (!toggleStop) chk({tag, "_hlat"}, 256'(w), 256'(0));
        chk({tag, "_hdr"}, 256'(d), 256'(rsp(8'h02, tg, st)));
        chk({tag, "_heofc"}, 256'(e), 256'(nd == 0 ? 8'd3 : 8'd0));
        for (int i = 0; i < nd; i++) begin
            x = (i == 0) ? x0 : (i == 1) ? x1 : x2;
            getFlit(e, d, w);
            chk($sformatf("%s_d%0d", tag, i), 256'(d), 256'(x));
            chk($sformatf("%s_e%0d", tag, i), 256'(e),
                256'(i == nd - 1 ? lastE : 8'd0));
            if (!toggleStop) begin
                chk($sformatf("%s_gap%0d", tag, i), 256'(w),
                    256'(i == 0 ? 1 : 0));
            end
        end
        quiet({tag, "_end"}, 4);
    endtask

    initial begin
        srst = 1'b1;
        smiReqReady = 1'b0;
        smiReqEofc = 8'd0;
        smiReqData = '0;
        smiRespStop = 1'b0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        chk("rst_reqStop", 256'(smiReqStop), 256'(0));
        chk("rst_ready", 256'(smiRespReady), 256'(0));
        chk("rst_eofc", 256'(smiRespEofc), 256'(0));
        chk("rst_data", 256'(smiRespData), 256'(0));

        // Pre-fill word 6 so the partial write can be seen to preserve bytes
        sendFlit(8'd0, hdr(8'h01, 8'h11, 64'h60, 16'd0), 0);
        sendFlit(8'd16, P, 1);
        wrResp("fill", 8'h11, 8'h00);

        sendFlit(8'd0, hdr(8'h01, 8'h5A, 64'h40, 16'd0), 0);
        sendFlit(8'd0, D0, 0);
        sendFlit(8'd0, D1, 0);
        sendFlit(8'd4, D2, 1);
        wrResp("wr", 8'h5A, 8'h00);

        w6 = {P[127:32], D2[31:0]};
        doRead("rd", 64'h40, 16'd36, 8'h21, 8'h00, 3, D0, D1, w6, 8'd4);

        toggleStop = 1;
        doRead("rdStop", 64'h40, 16'd36, 8'h22, 8'h00, 3, D0, D1, w6, 8'd4);
        toggleStop = 0;
        smiRespStop = 1'b0;

        doRead("rdOor", 64'h3FF0, 16'd32, 8'h23, 8'h01, 0, '0, '0, '0, 8'd0);

        sendFlit(8'd0, hdr(8'h01, 8'h24, 64'h3FF0, 16'd0), 0);
        sendFlit(8'd0, Q0, 0);
        sendFlit(8'd16, Q1, 1);
        wrResp("wrOor", 8'h24, 8'h01);
        doRead("rdLast", 64'h3FF0, 16'd16, 8'h25, 8'h00, 1, Q0, '0, '0,
               8'd16);

        sendFlit(8'd0, hdr(8'h07, 8'h26, 64'h40, 16'd16), 0);
        sendFlit(8'd0, D2, 0);
        sendFlit(8'd5, D2, 1);
        quiet("unkQuiet", 4);
        doRead("rdAfterUnk", 64'h50, 16'd16, 8'h27, 8'h00, 1, D1, '0, '0,
               8'd16);

        sendFlit(8'd16, hdr(8'h02, 8'h28, 64'h40, 16'd36), 1);
        @(negedge clk);
        chk("rstRd_hdrReady", 256'(smiRespReady), 256'(1));
        @(negedge clk);
        smiRespStop = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstRd_flit0", 256'({smiRespReady, smiRespData}),
            256'({1'b1, D0}));
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        smiRespStop = 1'b0;
        chk("rstRd_ready", 256'(smiRespReady), 256'(0));
        chk("rstRd_idle", 256'(smiReqStop), 256'(0));
        doRead("rdPostRst", 64'h45, 16'd36, 8'h29, 8'h00, 3, D0, D1, w6,
               8'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
